// File: rtl/serial_pattern_tx.sv
// Serializes one accepted WIDTH-bit word MSB-first (first bit on the accept edge) and counts overlapping "1010" in it.
// Busy for WIDTH+1 edges after accept (ready low); out_valid high WIDTH cycles, then a one-cycle done pulse.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-2:0]   r_shift, w_shift_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [2:0]         r_hist, w_hist_nxt;
  logic               r_out, w_out_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic               r_done, w_done_nxt;
  logic [CNT_W-1:0]   r_pat_cnt, w_pat_cnt_nxt;

  logic               w_bit;
  logic               w_last;
  logic               w_match;
  logic               w_accept;

  // The MSB leaves on the accept edge, so only the lower WIDTH-1 bits are held.
  assign w_bit    = r_shift[WIDTH-2];
  assign w_last   = (r_idx == '0);
  assign w_match  = ({r_hist, w_bit} == 4'b1010);
  assign w_accept = (r_state == IDLE) && valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (valid) w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready           = (r_state == IDLE);
    w_out_nxt       = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_shift_nxt     = r_shift;
    w_idx_nxt       = r_idx;
    w_hist_nxt      = r_hist;
    w_pat_cnt_nxt   = r_pat_cnt;
    if (w_accept) begin
      w_shift_nxt     = data[WIDTH-2:0];
      w_out_nxt       = data[WIDTH-1];
      w_out_valid_nxt = 1'b1;
      w_idx_nxt       = IDX_W'(WIDTH - 1);
      // History starts empty; the first emitted bit is its first entry.
      w_hist_nxt      = {2'b00, data[WIDTH-1]};
      w_pat_cnt_nxt   = '0;
    end else if (r_state == SHIFT) begin
      if (w_last) begin
        w_done_nxt = 1'b1;
      end else begin
        w_shift_nxt     = {r_shift[WIDTH-3:0], 1'b0};
        w_out_nxt       = w_bit;
        w_out_valid_nxt = 1'b1;
        w_idx_nxt       = r_idx - IDX_W'(1);
        w_hist_nxt      = {r_hist[1:0], w_bit};
        if (w_match && (r_pat_cnt != {CNT_W{1'b1}})) begin
          w_pat_cnt_nxt = r_pat_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= '0;
      r_idx       <= '0;
      r_hist      <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_pat_cnt   <= '0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_idx       <= w_idx_nxt;
      r_hist      <= w_hist_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_done      <= w_done_nxt;
      r_pat_cnt   <= w_pat_cnt_nxt;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign pat_cnt   = r_pat_cnt;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomized scoreboard bench for serial_pattern_tx: an 8-bit instance under random traffic and resets,
// plus a 16-bit instance with a 2-bit counter for saturation.
module tb_serial_pattern_tx;

  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int W2  = 16;
  localparam int CW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, valid, ready, out, out_valid, done;
  logic [W-1:0]  data;
  logic [CW-1:0] pat_cnt;

  logic           reset2, valid2, ready2, out2, out_valid2, done2;
  logic [W2-1:0]  data2;
  logic [CW2-1:0] pat_cnt2;

  serial_pattern_tx #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready),
    .out(out), .out_valid(out_valid), .done(done), .pat_cnt(pat_cnt)
  );

  serial_pattern_tx #(.WIDTH(W2), .CNT_W(CW2)) u_dut16 (
    .clk(clk), .reset(reset2), .data(data2), .valid(valid2), .ready(ready2),
    .out(out2), .out_valid(out_valid2), .done(done2), .pat_cnt(pat_cnt2)
  );

  typedef struct {
    bit is_done;
    bit b;
    int c;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   busy       = 0;
  int   last_final = 0;
  int   n_acc      = 0;
  bit   mon_en     = 1'b0;

  // Matches among the first k+1 emitted bits (MSB first), capped at maxv.
  function automatic int pat_upto(logic [15:0] w, int width, int k, int maxv);
    int n = 0;
    for (int j = 3; j <= k; j++) begin
      if (w[width+2-j] == 1'b1 && w[width+1-j] == 1'b0 &&
          w[width-j] == 1'b1 && w[width-1-j] == 1'b0) n++;
    end
    if (n > maxv) n = maxv;
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: decides acceptance from its own busy count and queues the expected word.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        busy = 0;
        sb_q.delete();
        last_final = 0;
      end else if (busy == 0 && valid) begin
        for (int k = 0; k < W; k++) begin
          sb_q.push_back('{is_done: 1'b0, b: data[W-1-k],
                           c: pat_upto({8'h00, data}, W, k, (1 << CW) - 1)});
        end
        last_final = pat_upto({8'h00, data}, W, W - 1, (1 << CW) - 1);
        sb_q.push_back('{is_done: 1'b1, b: 1'b0, c: last_final});
        busy = W + 1;
        n_acc++;
      end else if (busy > 0) begin
        busy--;
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("ready", ready, busy == 0);
        chk("out_valid", out_valid, busy >= 2);
        chk("done", done, busy == 1);
        if (out_valid === 1'b1) begin
          if (sb_q.size() == 0 || sb_q[0].is_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_bit: got out_valid=1 expected no bit at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            chk("out_bit", out, e.b);
            chk("pat_cnt", pat_cnt, e.c);
          end
        end else if (done === 1'b1) begin
          if (sb_q.size() == 0 || !sb_q[0].is_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            chk("done_cnt", pat_cnt, e.c);
            chk("done_out", out, 0);
          end
        end else begin
          chk("idle_out", out, 0);
          if (busy == 0) chk("hold_cnt", pat_cnt, last_final);
        end
      end
    end
  end

  task automatic send(logic [W-1:0] w);
    int start = n_acc;
    valid = 1'b1;
    data  = w;
    for (int i = 0; i < 40 && n_acc == start; i++) @(negedge clk);
    if (n_acc == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected one within 40 cycles");
    end
    valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int start;
    int gap;
    reset  = 1'b1;
    valid  = 1'b0;
    data   = '0;
    reset2 = 1'b1;
    valid2 = 1'b0;
    data2  = '0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    send(8'hAA); idle(10); chk("aa_final", pat_cnt, 3);
    send(8'h1A); idle(10); chk("1a_final", pat_cnt, 1);
    send(8'hFF); idle(10); chk("ff_final", pat_cnt, 0);

    // Back-to-back with valid held: the second accept must land WIDTH+2 edges later.
    start = n_acc;
    valid = 1'b1;
    data  = 8'hAA;
    for (int i = 0; i < 40 && n_acc == start; i++) @(negedge clk);
    data = 8'h1A;
    gap  = 0;
    for (int i = 0; i < 40 && n_acc == start + 1; i++) begin
      @(negedge clk);
      gap++;
    end
    valid = 1'b0;
    chk("b2b_gap", gap, W + 2);
    idle(12);

    // Reset in the middle of a word.
    send(8'hAA);
    idle(3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_vld", out_valid, 0);
    chk("rst_mid_cnt", pat_cnt, 0);
    chk("rst_mid_rdy", ready, 1);
    send(8'h1A); idle(10); chk("post_rst_cnt", pat_cnt, 1);

    // Data and valid toggling while shifting must be ignored.
    start = n_acc;
    send(8'hAA);
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      data  = (i % 2 == 0) ? 8'h00 : W'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
    idle(8);
    chk("no_extra_acc", n_acc, start + 1);
    chk("toggle_final", pat_cnt, 3);

    repeat (400) begin
      @(negedge clk);
      valid = 1'($urandom_range(0, 1));
      data  = W'($urandom);
      reset = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b0;
    idle(12);
    chk("sb_empty", sb_q.size(), 0);

    // 16-bit word with a 2-bit saturating counter.
    @(negedge clk);
    reset2 = 1'b0;
    chk("w16_ready", ready2, 1);
    valid2 = 1'b1;
    data2  = 16'hAAAA;
    @(negedge clk);
    valid2 = 1'b0;
    data2  = 16'h0000;
    for (int k = 0; k < W2; k++) begin
      chk("w16_vld", out_valid2, 1);
      chk("w16_bit", out2, (k % 2 == 0) ? 1 : 0);
      chk("w16_cnt", pat_cnt2, pat_upto(16'hAAAA, W2, k, (1 << CW2) - 1));
      @(negedge clk);
    end
    chk("w16_done", done2, 1);
    @(negedge clk);
    chk("w16_sat", pat_cnt2, 3);
    chk("w16_idle", ready2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Transmit-side counterpart of the serial "1010" sequence detector.
- Accepts a parallel word over a valid/ready handshake and serializes it MSB-first, one bit per clock, onto a single-bit stream.
- That stream is driven directly into the detector's serial input.
- Also counts overlapping "1010" occurrences in each emitted word, so benches can cross-check the detector's output pulses.

Parameters:
- WIDTH, 8: bits per word; must be >= 4.
- CNT_W, 4: width of the pattern counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data  in  WIDTH  word to transmit; sampled only at the accept edge.
- valid  in  1  producer has a word on data.
- ready  out  1  block can accept a word; combinational, = (state==IDLE).
- out  out  1  serial bit stream, registered.
- out_valid  out  1  out carries a word bit this cycle, registered.
- done  out  1  one-cycle pulse after the last bit, registered.
- pat_cnt  out  CNT_W  count of overlapping "1010" in bits emitted for the current/last word; saturating.

Behaviour:
- Reset (synchronous, any state, including mid-word):
  - Next edge: state=IDLE, out=0, out_valid=0, done=0, pat_cnt=0, shift register and bit history cleared.
  - A partially sent word is discarded; nothing resumes after reset.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1, out=0, out_valid=0, done=0.
  - Accept edge = edge with valid&&ready sampled high.
  - At the accept edge: latch data; out<=data[WIDTH-1]; out_valid<=1; bit index<=WIDTH-1; pat_cnt<=0; history<=0; state<=SHIFT.
- SHIFT:
  - ready=0. valid and data are ignored; changing data mid-word has no effect.
  - Each edge drives the next lower bit on out.
  - Edge k after accept (k=1..WIDTH-1): out=latched bit WIDTH-1-k.
  - Edge WIDTH after accept: out<=0, out_valid<=0, done<=1, state<=DONE.
  - Net: out_valid is high for exactly WIDTH cycles; bits appear MSB-first.
- DONE:
  - ready=0. Next edge: done<=0, state<=IDLE.
- Throughput: with valid held high, accepts occur every WIDTH+2 edges. For WIDTH=8, accept edges are 0, 10, 20, ...
- Pattern counter:
  - Window = last 4 emitted bits of the current word, oldest first.
  - At the edge that drives a bit onto out, if the window including that bit equals 1,0,1,0, pat_cnt increments in the same edge. pat_cnt is therefore valid alongside the bit that completes the pattern.
  - Overlaps count: "101010" gives 2.
  - No matches span word boundaries; history is cleared at accept.
  - Saturates at 2^CNT_W-1, no wrap.
  - Holds its final value through DONE and IDLE until the next accept clears it.
- Simultaneous events: reset has priority over accept and shifting. A valid arriving in the DONE cycle is not accepted until the cycle after, in IDLE.
- Width rules: bit index counter is $clog2(WIDTH) bits; history register is 3 bits.

Test Plan:
- reset=1 for 2 edges, then valid=1, data=8'b10101010 → out 1,0,1,0,1,0,1,0 on edges 0..7 after accept; out_valid high 8 cycles; done pulse at edge 8; pat_cnt steps 0,0,0,1,1,2,2,3 and holds 3.
- data=8'h1A (00011010) → out 0,0,0,1,1,0,1,0; pat_cnt=1 from edge 7; data=8'hFF → pat_cnt stays 0.
- valid held high with data=8'hAA then 8'h1A (producer switches on first accept) → accepts at edges 0 and 10; ready low for edges 1..9; pat_cnt cleared to 0 at edge 10; word-2 bits start there.
- Accept 8'hAA, reset=1 at edge 3 for one edge → edge 4: out=0, out_valid=0, pat_cnt=0, ready=1; no done pulse; a new word is accepted normally afterwards.
- During SHIFT, toggle data to 8'h00 with valid=1 → transmitted bits unchanged from the latched word; no extra accept.
- WIDTH=16, CNT_W=2, data=16'hAAAA → 7 true matches; pat_cnt saturates at 3 and holds.
